// File: rtl/bcd_pkg.sv
// bcd_pkg: shared packed-BCD constants and helpers for the time/date field counters
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int n;
        r = '0;
        n = v;
        for (int i = 0; i < 8; i++) begin
            r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction
    function automatic logic bcd_valid(input logic [BCD_DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction
endpackage

// File: rtl/bcd_counter_digit_step.sv
// bcd_digit_step: one BCD digit of a ripple +1/-1 with carry/borrow in and out
module bcd_digit_step import bcd_pkg::*; (
    input  logic [BCD_DIGIT_W-1:0] digit,
    input  logic                   up,
    input  logic                   step_in,
    output logic [BCD_DIGIT_W-1:0] next_digit,
    output logic                   step_out
);
    logic at_end;
    assign at_end = up ? digit == 4'd9 : digit == 4'd0;
    assign step_out = step_in && at_end;
    assign next_digit = !step_in ? digit :
                        at_end   ? (up ? 4'd0 : 4'd9) :
                        up       ? digit + 4'd1 : digit - 4'd1;
endmodule

// File: rtl/bcd_counter.sv
// bcd_counter: packed-BCD up/down field counter with whole-value MIN/MAX wrap and validated load
module bcd_counter import bcd_pkg::*; #(
    parameter  int NUM_DIGITS = 2,
    parameter  int MIN_VALUE  = 0,
    parameter  int MAX_VALUE  = 59,
    localparam int WIDTH      = BCD_DIGIT_W * NUM_DIGITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] value_o,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             ovf_o,
    output logic             udf_o,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             load_err_o
);
    localparam logic [WIDTH-1:0] MIN_BCD = WIDTH'(to_bcd(MIN_VALUE));
    localparam logic [WIDTH-1:0] MAX_BCD = WIDTH'(to_bcd(MAX_VALUE));
    localparam longint LIMIT = longint'(10) ** NUM_DIGITS;
    if (MIN_VALUE > MAX_VALUE || longint'(MAX_VALUE) >= LIMIT) begin : g_bad_params
        $error("bcd_counter: need MIN_VALUE <= MAX_VALUE < 10**NUM_DIGITS");
    end
    logic [NUM_DIGITS:0]   step;
    logic [NUM_DIGITS-1:0] nib_ok;
    logic [WIDTH-1:0]      stepped;
    logic                  step_req, at_limit, load_ok;
    assign step[0] = 1'b1;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (value_o[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .up         (inc_i),
            .step_in    (step[i]),
            .next_digit (stepped[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .step_out   (step[i+1])
        );
        assign nib_ok[i] = bcd_valid(load_value_i[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    // Valid BCD orders like its binary image, so limits compare directly.
    // A ripple out of the top digit can only happen at a limit, so it also counts as a wrap.
    assign step_req = !load_i && (inc_i ^ dec_i);
    assign at_limit = step[NUM_DIGITS] || value_o == (inc_i ? MAX_BCD : MIN_BCD);
    assign ovf_o    = step_req && inc_i && at_limit;
    assign udf_o    = step_req && dec_i && at_limit;
    assign load_ok  = &nib_ok && load_value_i >= MIN_BCD && load_value_i <= MAX_BCD;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_o    <= MIN_BCD;
            load_err_o <= 1'b0;
        end else begin
            load_err_o <= load_i && !load_ok;
            value_o    <= load_i   ? (load_ok ? load_value_i : value_o) :
                          ovf_o    ? MIN_BCD :
                          udf_o    ? MAX_BCD :
                          step_req ? stepped : value_o;
        end
    end
endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: hours, day-of-month and a seconds->minutes cascade checked against an integer model
module tb_bcd_counter;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic [3:0] rst = '1, inc = '0, dec = '0, ld = '0;
    logic [7:0] ldv [4] = '{default: 8'h00};
    logic [7:0] val [4];
    logic [3:0] ovf, udf, err;
    int mn [4] = '{0, 1, 0, 0};
    int mx [4] = '{23, 31, 59, 59};
    int mv [4] = '{0, 1, 0, 0};
    bit me [4] = '{default: 1'b0};
    int checks = 0, errors = 0;
    bit armed = 1'b0;

    bcd_counter #(.NUM_DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(23)) u_hours (
        .clk_i(clk_i), .rst_i(rst[0]), .value_o(val[0]), .inc_i(inc[0]), .dec_i(dec[0]),
        .ovf_o(ovf[0]), .udf_o(udf[0]), .load_i(ld[0]), .load_value_i(ldv[0]), .load_err_o(err[0]));
    bcd_counter #(.NUM_DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(31)) u_day (
        .clk_i(clk_i), .rst_i(rst[1]), .value_o(val[1]), .inc_i(inc[1]), .dec_i(dec[1]),
        .ovf_o(ovf[1]), .udf_o(udf[1]), .load_i(ld[1]), .load_value_i(ldv[1]), .load_err_o(err[1]));
    bcd_counter #(.NUM_DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(59)) u_sec (
        .clk_i(clk_i), .rst_i(rst[2]), .value_o(val[2]), .inc_i(inc[2]), .dec_i(dec[2]),
        .ovf_o(ovf[2]), .udf_o(udf[2]), .load_i(ld[2]), .load_value_i(ldv[2]), .load_err_o(err[2]));
    bcd_counter #(.NUM_DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(59)) u_min (
        .clk_i(clk_i), .rst_i(rst[3]), .value_o(val[3]), .inc_i(ovf[2]), .dec_i(dec[3]),
        .ovf_o(ovf[3]), .udf_o(udf[3]), .load_i(ld[3]), .load_value_i(ldv[3]), .load_err_o(err[3]));

    function automatic logic [7:0] to_bcd8(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction
    function automatic int from_bcd8(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction
    function automatic bit legal(input int k, input logic [7:0] v);
        return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && from_bcd8(v) >= mn[k] && from_bcd8(v) <= mx[k];
    endfunction
    // Minutes are stepped by the seconds' wrap, not by their own inc line.
    function automatic bit inc_eff(input int k);
        return k == 3 ? (inc[2] && !dec[2] && !ld[2] && mv[2] == mx[2]) : inc[k];
    endfunction
    function automatic bit exp_ovf(input int k);
        return inc_eff(k) && !dec[k] && !ld[k] && mv[k] == mx[k];
    endfunction
    function automatic bit exp_udf(input int k);
        return dec[k] && !inc_eff(k) && !ld[k] && mv[k] == mn[k];
    endfunction

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin
        bit ie [4];
        for (int k = 0; k < 4; k++) ie[k] = inc_eff(k);
        for (int k = 0; k < 4; k++) begin
            if (rst[k]) begin
                mv[k] = mn[k];
                me[k] = 1'b0;
            end else begin
                me[k] = ld[k] && !legal(k, ldv[k]);
                if (ld[k]) begin
                    if (legal(k, ldv[k])) mv[k] = from_bcd8(ldv[k]);
                end else if (ie[k] && !dec[k]) mv[k] = mv[k] == mx[k] ? mn[k] : mv[k] + 1;
                else if (dec[k] && !ie[k]) mv[k] = mv[k] == mn[k] ? mx[k] : mv[k] - 1;
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk_i) begin
        if (armed) begin
            for (int k = 0; k < 4; k++) begin
                cmp($sformatf("model value[%0d]", k), val[k], to_bcd8(mv[k]));
                cmp($sformatf("model ovf[%0d]", k), 8'(ovf[k]), 8'(exp_ovf(k)));
                cmp($sformatf("model udf[%0d]", k), 8'(udf[k]), 8'(exp_udf(k)));
                cmp($sformatf("model load_err[%0d]", k), 8'(err[k]), 8'(me[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask
    task automatic load(input int k, input logic [7:0] v);
        ld[k] = 1'b1;
        ldv[k] = v;
        tick();
        ld[k] = 1'b0;
    endtask

    initial begin
        tick();
        rst = '0;
        cmp("reset hours", val[0], 8'h00);
        cmp("reset day", val[1], 8'h01);
        cmp("reset load_err", 8'(err), 8'h0);
        load(0, 8'h22);
        cmp("hours load 22", val[0], 8'h22);
        inc[0] = 1'b1;
        #1 cmp("hours 22 inc ovf", 8'(ovf[0]), 8'h0);
        tick();
        cmp("hours 23", val[0], 8'h23);
        #1 cmp("hours 23 inc ovf", 8'(ovf[0]), 8'h1);
        tick();
        inc[0] = 1'b0;
        cmp("hours wrap 00", val[0], 8'h00);
        load(0, 8'h09);
        inc[0] = 1'b1;
        tick();
        inc[0] = 1'b0;
        cmp("hours carry 10", val[0], 8'h10);
        dec[1] = 1'b1;
        #1 cmp("day 01 dec udf", 8'(udf[1]), 8'h1);
        tick();
        dec[1] = 1'b0;
        cmp("day wrap 31", val[1], 8'h31);
        load(1, 8'h10);
        dec[1] = 1'b1;
        tick();
        dec[1] = 1'b0;
        cmp("day borrow 09", val[1], 8'h09);
        load(1, 8'h1A);
        cmp("load 1A err", 8'(err[1]), 8'h1);
        cmp("load 1A holds", val[1], 8'h09);
        tick();
        cmp("load err one cycle", 8'(err[1]), 8'h0);
        load(1, 8'h32);
        cmp("load 32 err", 8'(err[1]), 8'h1);
        load(1, 8'h00);
        cmp("load 00 err", 8'(err[1]), 8'h1);
        cmp("load 00 holds", val[1], 8'h09);
        load(1, 8'h15);
        cmp("load 15 err", 8'(err[1]), 8'h0);
        cmp("load 15 value", val[1], 8'h15);
        load(1, 8'h31);
        ld[1] = 1'b1;
        ldv[1] = 8'h05;
        inc[1] = 1'b1;
        #1 cmp("load beats inc ovf", 8'(ovf[1]), 8'h0);
        tick();
        ld[1] = 1'b0;
        cmp("load beats inc value", val[1], 8'h05);
        dec[1] = 1'b1;
        #1 cmp("inc+dec ovf/udf", 8'({ovf[1], udf[1]}), 8'h0);
        tick();
        inc[1] = 1'b0;
        dec[1] = 1'b0;
        cmp("inc+dec holds", val[1], 8'h05);
        load(0, 8'h23);
        rst[0] = 1'b1;
        ld[0] = 1'b1;
        ldv[0] = 8'h2F;
        inc[0] = 1'b1;
        tick();
        {rst[0], ld[0], inc[0]} = 3'b000;
        cmp("reset beats load value", val[0], 8'h00);
        cmp("reset beats load err", 8'(err[0]), 8'h0);
        ld[2] = 1'b1;
        ld[3] = 1'b1;
        ldv[2] = 8'h59;
        ldv[3] = 8'h59;
        tick();
        ld[2] = 1'b0;
        ld[3] = 1'b0;
        inc[2] = 1'b1;
        #1 cmp("cascade sec ovf", 8'(ovf[2]), 8'h1);
        cmp("cascade min ovf", 8'(ovf[3]), 8'h1);
        tick();
        inc[2] = 1'b0;
        cmp("cascade sec 00", val[2], 8'h00);
        cmp("cascade min 00", val[3], 8'h00);
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                rst[k] = $urandom_range(0, 40) == 0;
                inc[k] = $urandom_range(0, 2) != 0;
                dec[k] = $urandom_range(0, 3) == 0;
                ld[k]  = $urandom_range(0, 5) == 0;
                ldv[k] = $urandom_range(0, 1) != 0 ? to_bcd8($urandom_range(0, 60)) : 8'($urandom);
            end
            tick();
        end
        rst = '0;
        inc = '0;
        dec = '0;
        ld = '0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Multi-digit packed-BCD counter for the clock's time and date fields, e.g. seconds 00-59, hours 00-23, day-of-month 01-31, month 01-12.
- Counts up or down between whole-field limits MIN_VALUE..MAX_VALUE, so wrap is decided on the full value and not per digit.
- Supports validated parallel load from the decoded time frame.
- Wrap outputs cascade into the next field's increment/decrement inputs.

Parameters:
- NUM_DIGITS, 2, number of BCD digits in the field.
- MIN_VALUE, 0, lowest legal decimal value; reset value and wrap target on increment.
- MAX_VALUE, 59, highest legal decimal value; wrap target on decrement; must be < 10**NUM_DIGITS.
- WIDTH, 4*NUM_DIGITS, packed BCD width; derived, not overridden.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- value_o  output  WIDTH  current value, packed BCD, digit 0 in [3:0]
- inc_i  input  1  increment request
- dec_i  input  1  decrement request
- ovf_o  output  1  combinational; inc wraps MAX->MIN this cycle
- udf_o  output  1  combinational; dec wraps MIN->MAX this cycle
- load_i  input  1  parallel load strobe
- load_value_i  input  WIDTH  packed BCD load value
- load_err_o  output  1  registered one-cycle pulse: last load rejected

Behaviour:
- Reset (rst_i=1 at posedge):
  - value_o <= BCD(MIN_VALUE); load_err_o <= 0.
  - Reset overrides all other inputs.
- Priority below reset: load_i > (inc_i XOR dec_i) > hold.
- Load:
  - Accepted only if every nibble is <= 9 and MIN_VALUE <= value <= MAX_VALUE.
  - Accepted: value_o <= load_value_i on the next edge; load_err_o <= 0.
  - Rejected: value_o holds; load_err_o <= 1 for exactly one cycle.
  - When load_i=1, inc/dec are ignored and ovf_o=udf_o=0.
- Load error timing: load_err_o <= 0 in every cycle without a rejected load.
- Increment (inc_i=1, dec_i=0, load_i=0):
  - If value == MAX_VALUE: value <= MIN_VALUE and ovf_o=1 in the same cycle.
  - Else: BCD +1 with per-digit carry (9->0, carry to next digit); ovf_o=0.
- Decrement (dec_i=1, inc_i=0, load_i=0):
  - If value == MIN_VALUE: value <= MAX_VALUE and udf_o=1 in the same cycle.
  - Else: BCD -1 with per-digit borrow (0->9, borrow from next digit); udf_o=0.
- inc_i and dec_i both 1: hold, ovf_o=udf_o=0.
- ovf_o and udf_o are never both 1. Both are gated by the request, so they can drive the next field's inc_i/dec_i directly; the chain ripples within one cycle.
- Latency: value_o changes one edge after the request; there is no bubble and every cycle can step.
- No illegal state is reachable; value_o is always valid BCD within [MIN, MAX].
- Elaboration check: if MIN_VALUE > MAX_VALUE or MAX_VALUE >= 10**NUM_DIGITS, raise $error.

Decomposition:
- Shared package bcd_pkg:
  - constant BCD_DIGIT_W = 4
  - function to_bcd(int) returning packed BCD, used for the MIN/MAX constants
  - function bcd_valid(nibble)
- Sub-module bcd_digit_step (one instance per digit, generate loop):
  - Inputs: digit, up, step_in (carry/borrow in).
  - Outputs: next digit, step_out.
- The top level does whole-value MIN/MAX compare, load validation, priority and the registers.

Test Plan:
- Hours (NUM_DIGITS=2, MIN=0, MAX=23):
  - 0x22 + inc -> 0x23, ovf_o=0.
  - 0x23 + inc -> 0x00, ovf_o=1 in the inc cycle.
  - 0x09 + inc -> 0x10 (carry).
- Day-of-month (MIN=1, MAX=31):
  - Reset -> 0x01.
  - dec at 0x01 -> 0x31, udf_o=1.
  - 0x10 + dec -> 0x09 (borrow).
- Load validation (MIN=1, MAX=31):
  - load 0x1A -> value holds, load_err_o=1 for one cycle.
  - load 0x32 or 0x00 -> rejected, load_err_o=1.
  - load 0x15 -> value 0x15, load_err_o=0.
- Simultaneous events:
  - load_i=1 with inc_i=1 at MAX -> load wins, ovf_o=0.
  - inc_i=dec_i=1 -> value holds, no ovf_o/udf_o.
- Reset mid-operation: rst_i with load_i and inc_i asserted at 0x23 -> next value MIN, load_err_o=0.
- Cascade: seconds (0-59) ovf_o into minutes inc_i at 0x59/0x59 + inc -> both 0x00 on the same edge, and minutes ovf_o=1.
